// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// A winning bundle is registered onto the ALU inputs, and the result comes back tagged with the requester ID.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [2:0]       req0_operation,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [2:0]       req1_operation,
    input  logic             req1_mode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_operation,
    output logic             alu_mode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [2:0]       opr_q, opr_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             grant_vld;
    logic             grant_id;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        opr_d        = opr_q;
        mode_d       = mode_q;
        out_d        = out_q;
        flags_d      = flags_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d      = ISSUE;
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    op1_d        = grant_id ? req1_op1 : req0_op1;
                    op2_d        = grant_id ? req1_op2 : req0_op2;
                    opr_d        = grant_id ? req1_operation : req0_operation;
                    mode_d       = grant_id ? req1_mode : req0_mode;
                end
            end
            ISSUE: begin
                // ALU inputs have been stable for a full cycle; its outputs are settled.
                state_d     = RESP;
                out_d       = alu_out;
                flags_d     = {alu_carry, alu_zero, alu_overflow, alu_sign};
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            opr_q        <= '0;
            mode_q       <= 1'b0;
            out_q        <= '0;
            flags_q      <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            opr_q        <= opr_d;
            mode_q       <= mode_d;
            out_q        <= out_d;
            flags_q      <= flags_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign alu_operation = opr_q;
    assign alu_mode      = mode_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = id_q;
    assign rsp_out       = out_q;
    assign rsp_flags     = flags_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a transaction-level model with a per-cycle compare, plus literal spot checks.
// The ALU stub adds the operands and reports flag_drv, but only while a transaction is being issued.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [2:0]  req0_operation = '0, req1_operation = '0;
    logic        req0_mode = 1'b0, req1_mode = 1'b0;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [2:0]  alu_operation;
    logic        alu_mode, alu_carry, alu_zero, alu_overflow, alu_sign;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
    logic [31:0] rsp_out;
    logic [3:0]  rsp_flags;

    logic [3:0]  flag_drv = 4'b0000;
    logic        chk_on = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_operation(req0_operation), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_operation(req1_operation), .req1_mode(req1_mode),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_flags(rsp_flags), .busy(busy)
    );

    // Reference model: phase 0 = waiting for a request, 1 = operation in the ALU, 2 = holding a response.
    int          m_phase;
    logic        m_last, m_id, m_mode, m_rv;
    logic [31:0] m_op1, m_op2, m_out;
    logic [2:0]  m_opr;
    logic [3:0]  m_flags;
    logic [1:0]  m_pick;
    logic        m_r0, m_r1;

    function automatic logic [1:0] pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return {1'b1, ~last};
        if (v0)       return 2'b10;
        if (v1)       return 2'b11;
        return 2'b00;
    endfunction

    assign m_pick = pick(req0_valid, req1_valid, m_last);
    assign m_r0   = (m_phase == 0) && (m_pick == 2'b10);
    assign m_r1   = (m_phase == 0) && (m_pick == 2'b11);

    // The ALU stub returns meaningful values only during the issue cycle, and garbage otherwise.
    assign alu_out = (m_phase == 1) ? alu_op1 + alu_op2 : 32'hDEAD_BEEF;
    assign {alu_carry, alu_zero, alu_overflow, alu_sign} = (m_phase == 1) ? flag_drv : ~flag_drv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_last <= 1'b1; m_id <= 1'b0; m_mode <= 1'b0; m_rv <= 1'b0;
            m_op1 <= '0; m_op2 <= '0; m_opr <= '0; m_out <= '0; m_flags <= '0;
        end else if (m_phase == 0) begin
            if (m_pick[1]) begin
                m_phase <= 1;
                m_id    <= m_pick[0];
                m_last  <= m_pick[0];
                m_op1   <= m_pick[0] ? req1_op1 : req0_op1;
                m_op2   <= m_pick[0] ? req1_op2 : req0_op2;
                m_opr   <= m_pick[0] ? req1_operation : req0_operation;
                m_mode  <= m_pick[0] ? req1_mode : req0_mode;
            end
        end else if (m_phase == 1) begin
            m_phase <= 2;
            m_rv    <= 1'b1;
            m_out   <= m_op1 + m_op2;
            m_flags <= flag_drv;
        end else if (rsp_ready) begin
            m_phase <= 0;
            m_rv    <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req0_ready", req0_ready, m_r0);
            chk("req1_ready", req1_ready, m_r1);
            chk("busy", busy, m_phase != 0);
            chk("alu_op1", alu_op1, m_op1);
            chk("alu_op2", alu_op2, m_op2);
            chk("alu_operation", alu_operation, m_opr);
            chk("alu_mode", alu_mode, m_mode);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_out", rsp_out, m_out);
            chk("rsp_flags", rsp_flags, m_flags);
        end
    end

    // Completed-response log, used to check grant order and per-requester payloads.
    logic        q_id[$];
    logic [31:0] q_out[$];
    logic [31:0] q_a1[$];
    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            q_id.push_back(rsp_id);
            q_out.push_back(rsp_out);
            q_a1.push_back(alu_op1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a1 [4];
        logic [31:0] exp_out[4];
        int n0;
        #1;
        do_reset();
        chk_on = 1'b1;

        // Single request from requester 0.
        req0_op1 = 32'd1; req0_op2 = 32'd1; req0_operation = 3'b000; req0_mode = 1'b0;
        req0_valid = 1'b1; rsp_ready = 1'b1; flag_drv = 4'b0000;
        @(negedge clk); chk("t1_req0_ready", req0_ready, 1);
        tick(); req0_valid = 1'b0;
        @(negedge clk); chk("t1_alu_op1", alu_op1, 1); chk("t1_alu_op2", alu_op2, 1);
        tick();
        @(negedge clk); chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_out", rsp_out, 32'h2); chk("t1_rsp_flags", rsp_flags, 4'b0000);
        tick();
        @(negedge clk); chk("t1_rsp_done", rsp_valid, 0); chk("t1_idle", busy, 0);

        // Continuous contention: grants must alternate starting with requester 0.
        do_reset();
        q_id.delete(); q_out.delete(); q_a1.delete();
        req0_op1 = 32'd3; req0_op2 = 32'd0; req0_operation = 3'b010; req0_mode = 1'b1;
        req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'd1; req1_operation = 3'b101; req1_mode = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_a1  = '{32'd3, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF};
        exp_out = '{32'd3, 32'd0, 32'd3, 32'd0};
        chk("t2_count", q_id.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_id.size()) begin
                chk("t2_rsp_id", q_id[i], i % 2);
                chk("t2_alu_op1", q_a1[i], exp_a1[i]);
                chk("t2_rsp_out", q_out[i], exp_out[i]);
            end
        end

        // Backpressure with flag capture; requesters stay valid but must not be accepted.
        tick();
        flag_drv = 4'b1011; rsp_ready = 1'b0;
        req0_op1 = 32'd7; req0_op2 = 32'd8; req0_valid = 1'b1;
        tick(); req0_valid = 1'b0;
        for (int i = 0; i < 8 && !rsp_valid; i++) tick();
        chk("t3_rsp_arrived", rsp_valid, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", rsp_valid, 1); chk("t3_hold_r0", req0_ready, 0);
            chk("t3_hold_r1", req1_ready, 0); chk("t3_hold_busy", busy, 1);
            chk("t3_hold_out", rsp_out, 32'd15); chk("t3_hold_flags", rsp_flags, 4'b1011);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        @(negedge clk); chk("t3_release_valid", rsp_valid, 0); chk("t3_release_idle", busy, 0);
        chk("t3_flags_kept", rsp_flags, 4'b1011);
        tick();

        // Reset while the operation is in the ALU; requester 0 last won, so only reset restores its priority.
        flag_drv = 4'b0000;
        req0_op1 = 32'd9; req0_op2 = 32'd9; req0_valid = 1'b1;
        tick(); req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); chk("t5_rst_valid", rsp_valid, 0); chk("t5_rst_alu", alu_op1, 0);
        chk("t5_rst_busy", busy, 0);
        tick(); rst_n = 1'b1;
        req0_op1 = 32'd11; req0_op2 = 32'd0; req1_op1 = 32'd22; req1_op2 = 32'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk); chk("t5_first_r0", req0_ready, 1); chk("t5_first_r1", req1_ready, 0);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        @(negedge clk); chk("t5_rsp_id", rsp_id, 0); chk("t5_rsp_out", rsp_out, 32'd11);
        tick();

        // Requester 1 pulses valid during a held response and then withdraws.
        req0_op1 = 32'd100; req0_op2 = 32'd1; req0_valid = 1'b1; rsp_ready = 1'b0;
        tick(); req0_valid = 1'b0;
        tick();
        req1_valid = 1'b1;
        @(negedge clk); chk("t6_r1_blocked", req1_ready, 0);
        tick(); req1_valid = 1'b0; rsp_ready = 1'b1;
        n0 = q_id.size();
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_idle_busy", busy, 0); chk("t6_idle_r0", req0_ready, 0);
            chk("t6_idle_r1", req1_ready, 0); chk("t6_idle_valid", rsp_valid, 0);
            tick();
        end
        chk("t6_one_rsp", q_id.size(), n0 + 1);
        if (q_id.size() > 0) chk("t6_rsp_owner", q_id[q_id.size()-1], 0);
        chk("t6_rsp_out", rsp_out, 32'd101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
